// File: rtl/fp_norm_pkg.sv
// Shared widths, flag indices and stage-1 classification for fp_norm_pipe.
// Rounding mode is selected by FP_NORM_ROUND_EN in fp_norm_pipe.sv.
package fp_norm_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UF   = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        K_NORM,
        K_ZERO,
        K_UF,
        K_SPEC
    } kind_t;

    // carry, hidden, fraction, G, R, S
    function automatic int sum_w(input int man_w);
        return man_w + 5;
    endfunction

endpackage

// File: rtl/fp_norm_pipe_lzc.sv
// Parametrised leading-zero counter; an all-zero input counts as W.
// Used by fp_norm_pipe for cancellation normalisation.
module lzc_nbit #(
    parameter int W = 14,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);

    // Highest set bit is visited last, so it wins.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (d[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage FP normaliser: LZC/shift/exp-adjust, then round/encode.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; default truncates.
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int SUM_W = sum_w(MAN_W)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [SUM_W-1:0]       in_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [2:0]             out_flags
);

    localparam int LZW = SUM_W - 1;
    localparam int LCW = $clog2(LZW + 1);
    localparam int EW1 = EXP_W + 1;
    localparam int FW  = MAN_W + 1;
    localparam logic signed [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};

    logic s1_valid;
    logic s2_valid;
    logic s1_advance;

    logic                  s1_sign;
    logic signed [EXP_W:0] s1_exp;
    logic [LZW-1:0]        s1_man;
    kind_t                 s1_kind;

    logic [LCW-1:0]        lz;
    logic signed [EXP_W:0] e_in;
    logic signed [EXP_W:0] e_lz;
    logic signed [EXP_W:0] e_d;
    logic [LZW-1:0]        man_d;
    kind_t                 kind_d;

    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_valid  = s2_valid;

    lzc_nbit #(
        .W(LZW)
    ) u_lzc (
        .d  (in_mant[LZW-1:0]),
        .cnt(lz)
    );

    always_comb begin
        e_in   = signed'({1'b0, in_exp});
        e_lz   = EW1'(lz);
        kind_d = K_NORM;
        e_d    = e_in;
        man_d  = '0;
        if (in_exp == '1) begin
            kind_d = K_SPEC;
            man_d[MAN_W+2:3] = in_mant[MAN_W+2:3];
            if (|in_mant[MAN_W+2:3]) man_d[MAN_W+2] = 1'b1;
        end else if (in_mant == '0) begin
            kind_d = K_ZERO;
        end else if (in_mant[SUM_W-1]) begin
            // Shifted-out bit folds into sticky.
            e_d   = e_in + EW1'(1);
            man_d = {in_mant[SUM_W-1:2], |in_mant[1:0]};
        end else if (e_lz >= e_in) begin
            kind_d = K_UF;
        end else begin
            e_d   = e_in - e_lz;
            man_d = in_mant[LZW-1:0] << lz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_kind  <= K_NORM;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= e_d;
                s1_man  <= man_d;
                s1_kind <= kind_d;
            end
        end
    end

    logic [MAN_W-1:0]      frac;
    logic                  inc;
    logic [MAN_W:0]        fsum;
    logic signed [EXP_W:0] e_r;
    logic                  ovf;
    logic [EXP_W+MAN_W:0]  res_d;
    logic [2:0]            flg_d;

    always_comb begin
        frac = MAN_W'(s1_man >> 3);
`ifdef FP_NORM_ROUND_EN
        inc = s1_man[2] && (s1_man[1] || s1_man[0] || frac[0]);
`else
        inc = 1'b0;
`endif
        fsum = {1'b0, frac} + FW'(inc);
        e_r  = s1_exp + EW1'(fsum[MAN_W]);
        // First term covers the carry case where e_r would wrap.
        ovf  = (s1_exp >= EMAX) || (e_r >= EMAX);
        res_d = '0;
        res_d[EXP_W+MAN_W] = s1_sign;
        flg_d = '0;
        unique case (s1_kind)
            K_SPEC: res_d[EXP_W+MAN_W-1:0] = {{EXP_W{1'b1}}, frac};
            K_ZERO: flg_d[FLAG_ZERO] = 1'b1;
            K_UF:   flg_d[FLAG_UF] = 1'b1;
            default: begin
                if (ovf) begin
                    res_d[EXP_W+MAN_W-1:0] = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flg_d[FLAG_OVF] = 1'b1;
                end else begin
                    res_d[EXP_W+MAN_W-1:0] = {EXP_W'(e_r), fsum[MAN_W-1:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
                out_flags  <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Scoreboard bench for fp_norm_pipe (default widths).
// Honours FP_NORM_ROUND_EN for rounding-dependent expectations.
module tb_fp_norm_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = '0;
    logic [14:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    fp_norm_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit lat_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [18:0] v;
        int          c;
    } sb_t;
    sb_t q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] model(input logic s, input int e,
                                          input int m);
        int lz;
        int fr;
        if (e == 31) begin
            fr = (m >> 3) & 'h3FF;
            if (fr != 0) fr = fr | 'h200;
            return {s, 5'h1F, 10'(fr), 3'b000};
        end
        if (m == 0) return {s, 15'd0, 3'b001};
        if ((m & 'h4000) != 0) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else begin
            lz = 0;
            while ((m & 'h2000) == 0) begin
                m = m << 1;
                lz++;
            end
            if (lz >= e) return {s, 15'd0, 3'b010};
            e = e - lz;
        end
        fr = (m >> 3) & 'h3FF;
`ifdef FP_NORM_ROUND_EN
        if (((m >> 2) & 1) == 1 && ((m & 3) != 0 || (fr & 1) == 1))
            fr = fr + 1;
`endif
        if (fr == 'h400) begin
            fr = 0;
            e = e + 1;
        end
        if (e >= 31) return {s, 5'h1F, 10'd0, 3'b100};
        return {s, 5'(e), 10'(fr), 3'b000};
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [4:0] e,
                         input logic [14:0] m, input logic ordy,
                         input logic [18:0] expv, output bit acc);
        sb_t t;
        @(negedge clk);
        in_valid  = v;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("stale", 1, 0);
            end else begin
                t = q.pop_front();
                check("res", out_result, t.v[18:3]);
                check("flg", out_flags, t.v[2:0]);
                if (lat_on) check("lat", cyc - t.c, 2);
            end
        end
        if (acc) q.push_back('{expv, cyc});
    endtask

    task automatic send(input logic s, input logic [4:0] e,
                        input logic [14:0] m, input logic [18:0] expv);
        bit acc;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, s, e, m, 1'b1, expv, acc);
            if (acc) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 30 && q.size() != 0; i++)
            cycle(1'b0, 1'b0, 5'd0, 15'd0, 1'b1, 19'd0, acc);
        check("drain", q.size(), 0);
    endtask

`ifdef FP_NORM_ROUND_EN
    localparam logic [15:0] R_A = 16'h4000;
    localparam logic [15:0] R_B = 16'h7C00;
    localparam logic [2:0]  F_B = 3'b100;
`else
    localparam logic [15:0] R_A = 16'h3FFF;
    localparam logic [15:0] R_B = 16'h7BFF;
    localparam logic [2:0]  F_B = 3'b000;
`endif

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [14:0] m;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    vec_t dir[13] = '{
        '{1'b0, 5'd15, 15'h4000, 16'h4000, 3'b000},
        '{1'b0, 5'd15, 15'h1000, 16'h3800, 3'b000},
        '{1'b0, 5'd2,  15'h0100, 16'h0000, 3'b010},
        '{1'b0, 5'd15, 15'h3FFC, R_A,      3'b000},
        '{1'b1, 5'd30, 15'h4000, 16'hFC00, 3'b100},
        '{1'b1, 5'd30, 15'h0000, 16'h8000, 3'b001},
        '{1'b0, 5'd31, 15'h0000, 16'h7C00, 3'b000},
        '{1'b1, 5'd31, 15'h0008, 16'hFE01, 3'b000},
        '{1'b0, 5'd1,  15'h1000, 16'h0000, 3'b010},
        '{1'b0, 5'd2,  15'h1000, 16'h0400, 3'b000},
        '{1'b0, 5'd20, 15'h0001, 16'h1C00, 3'b000},
        '{1'b0, 5'd30, 15'h3FFC, R_B,      F_B},
        '{1'b0, 5'd0,  15'h4000, 16'h0400, 3'b000}
    };

    initial begin
        bit acc;
        logic [14:0] m;
        logic [4:0] e;
        logic s;
        logic [14:0] bm[3];

        #1;
        check("rst_ov", out_valid, 0);
        check("rst_res", out_result, 0);
        check("rst_flg", out_flags, 0);
        check("rst_rdy", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        lat_on = 1'b1;
        foreach (dir[i]) send(dir[i].s, dir[i].e, dir[i].m, {dir[i].r, dir[i].f});
        drain();
        lat_on = 1'b0;

        bm = '{15'h4000, 15'h0123, 15'h2AAA};
        cycle(1'b1, 1'b0, 5'd10, bm[0], 1'b0, model(1'b0, 10, bm[0]), acc);
        check("bp_acc0", acc, 1);
        cycle(1'b1, 1'b1, 5'd20, bm[1], 1'b0, model(1'b1, 20, bm[1]), acc);
        check("bp_acc1", acc, 1);
        cycle(1'b1, 1'b0, 5'd12, bm[2], 1'b0, model(1'b0, 12, bm[2]), acc);
        check("bp_rdy", in_ready, 0);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 1'b0, 5'd12, bm[2], 1'b0, model(1'b0, 12, bm[2]), acc);
        check("bp_hold", out_valid, 1);
        for (int i = 0; i < 10 && !acc; i++)
            cycle(1'b1, 1'b0, 5'd12, bm[2], 1'b1, model(1'b0, 12, bm[2]), acc);
        check("bp_acc2", acc, 1);
        drain();

        cycle(1'b1, 1'b0, 5'd9, 15'h0F00, 1'b0, model(1'b0, 9, 'h0F00), acc);
        cycle(1'b1, 1'b1, 5'd9, 15'h0300, 1'b0, model(1'b1, 9, 'h0300), acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("pre_rst_ov", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_res", out_result, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_rdy", in_ready, 1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 5'd0, 15'd0, 1'b1, 19'd0, acc);
        check("rel_ov", out_valid, 0);

        for (int i = 0; i < 80; i++) begin
            s = 1'($urandom_range(0, 1));
            e = 5'($urandom_range(0, 31));
            m = 15'($urandom_range(0, 32767) >> $urandom_range(0, 14));
            cycle(1'($urandom_range(0, 3) != 0), s, e, m,
                  1'($urandom_range(0, 9) < 7), model(s, e, m), acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
